// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: stage stall/flush,
// EX operand forwarding, data-memory wait FSM with timeout, and perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_rs1_addr_id,
    input  logic [4:0]       i_rs2_addr_id,
    input  logic             i_rs1_hazard_on_id,
    input  logic             i_rs2_hazard_on_id,
    input  logic [4:0]       i_rs1_addr_ex,
    input  logic [4:0]       i_rs2_addr_ex,
    input  logic [4:0]       i_rd_addr_ex,
    input  logic [4:0]       i_rd_addr_mem,
    input  logic [4:0]       i_rd_addr_wb,
    input  logic             i_reg_wren_ex,
    input  logic             i_reg_wren_mem,
    input  logic             i_reg_wren_wb,
    input  logic             i_is_load_ex,
    input  logic             i_br_taken_ex,
    input  logic             i_mem_req_mem,
    input  logic             i_mem_ack,
    output logic             o_stall_if,
    output logic             o_stall_id,
    output logic             o_stall_ex,
    output logic             o_stall_mem,
    output logic             o_flush_id,
    output logic             o_flush_ex,
    output logic             o_flush_wb,
    output logic [1:0]       o_fwd_a_sel_ex,
    output logic [1:0]       o_fwd_b_sel_ex,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              mem_wait_c;
    logic              load_use_c;
    logic [1:0]        fwd_a_c;
    logic [1:0]        fwd_b_c;

    // Hazard detection; the ack-completion cycle is not a wait cycle.
    always_comb begin
        mem_wait_c = ((state_q == ST_MEM_WAIT) && !i_mem_ack) ||
                     ((state_q == ST_RUN) && i_mem_req_mem && !i_mem_ack);
        load_use_c = i_is_load_ex && i_reg_wren_ex && (i_rd_addr_ex != 5'd0) &&
                     (((i_rs1_addr_id == i_rd_addr_ex) && i_rs1_hazard_on_id) ||
                      ((i_rs2_addr_id == i_rd_addr_ex) && i_rs2_hazard_on_id));
    end

    // Forwarding: youngest producer (MEM) wins; x0 never forwards.
    always_comb begin
        fwd_a_c = 2'b00;
        if (i_reg_wren_mem && (i_rd_addr_mem != 5'd0) && (i_rd_addr_mem == i_rs1_addr_ex)) begin
            fwd_a_c = 2'b01;
        end else if (i_reg_wren_wb && (i_rd_addr_wb != 5'd0) && (i_rd_addr_wb == i_rs1_addr_ex)) begin
            fwd_a_c = 2'b10;
        end
        fwd_b_c = 2'b00;
        if (i_reg_wren_mem && (i_rd_addr_mem != 5'd0) && (i_rd_addr_mem == i_rs2_addr_ex)) begin
            fwd_b_c = 2'b01;
        end else if (i_reg_wren_wb && (i_rd_addr_wb != 5'd0) && (i_rd_addr_wb == i_rs2_addr_ex)) begin
            fwd_b_c = 2'b10;
        end
    end

    // Prioritised stall/flush; lower-priority events are dropped, not queued.
    always_comb begin
        o_stall_if     = 1'b0;
        o_stall_id     = 1'b0;
        o_stall_ex     = 1'b0;
        o_stall_mem    = 1'b0;
        o_flush_id     = 1'b0;
        o_flush_ex     = 1'b0;
        o_flush_wb     = 1'b0;
        o_fwd_a_sel_ex = 2'b00;
        o_fwd_b_sel_ex = 2'b00;
        if (!i_rst_n) begin
            o_flush_id = 1'b1;
            o_flush_ex = 1'b1;
            o_flush_wb = 1'b1;
        end else begin
            o_fwd_a_sel_ex = fwd_a_c;
            o_fwd_b_sel_ex = fwd_b_c;
            if (mem_wait_c || (state_q == ST_ERR)) begin
                o_stall_if  = 1'b1;
                o_stall_id  = 1'b1;
                o_stall_ex  = 1'b1;
                o_stall_mem = 1'b1;
                o_flush_wb  = 1'b1;
            end else if (i_br_taken_ex) begin
                o_flush_id = 1'b1;
                o_flush_ex = 1'b1;
            end else if (load_use_c) begin
                o_stall_if = 1'b1;
                o_stall_id = 1'b1;
                o_flush_ex = 1'b1;
            end
        end
    end

    // Memory-wait FSM and counter next-state.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (i_mem_req_mem && !i_mem_ack) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (i_mem_ack) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        mem_timeout_d = (state_d == ST_ERR);
        if (o_stall_if) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (o_flush_id || o_flush_ex) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign o_mem_timeout = mem_timeout_q;
    assign o_stall_cnt   = stall_cnt_q;
    assign o_flush_cnt   = flush_cnt_q;

endmodule
